// File: rtl/serial_add_seq.sv
// serial_add_seq
//    Runs one 4-bit generate/propagate adder slice across a 4*NIBBLES-bit
//    operand, one nibble per clock. It supports add and subtract, and the
//    carry between nibbles is held in a register. Subtract is done as
//    A + ~B + 1: B is inverted at accept and the carry starts at 1.
//
//    State table:
//       state  | meaning
//       IDLE   | waiting for start
//       RUN    | processing nibble k; busy high
//       DONE   | result valid, done pulse; start re-enters RUN directly
//
// Ports
//    clk     in   system clock, rising edge
//    rst_n   in   asynchronous active-low reset
//    start   in   request an operation (accepted in IDLE or DONE)
//    op_sub  in   0 = a+b, 1 = a-b, sampled with start
//    a_in    in   operand A, sampled with start
//    b_in    in   operand B, sampled with start
//    busy    out  high while nibbles are being processed
//    done    out  one-cycle pulse when the result is valid
//    sum     out  result, held until the next accepted start
//    cout    out  carry out of the MSB (for subtract: 1 = no borrow)
//    ovf     out  two's-complement overflow

module serial_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic [4*NIBBLES-1:0] a_in,
   input  logic [4*NIBBLES-1:0] b_in,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = $clog2(NIBBLES);
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            c_q;
   logic [KW-1:0]   k_q;
   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    sum_q;
   logic            cout_q;
   logic            ovf_q;

   logic [3:0]      a_nib;
   logic [3:0]      b_nib;
   logic [3:0]      gen_d;
   logic [3:0]      prop_d;
   logic [4:0]      carry_d;
   logic [3:0]      nib_sum_d;

   // Nibble select for the current slice.
   always_comb begin
      a_nib = 4'h0;
      b_nib = 4'h0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (k_q == KW'(n)) begin
            a_nib = a_q[4*n +: 4];
            b_nib = b_q[4*n +: 4];
         end
      end
   end

   // One 4-bit slice: this is the only carry chain that ripples within a cycle.
   always_comb begin
      gen_d      = a_nib & b_nib;
      prop_d     = a_nib | b_nib;
      carry_d    = 5'b0;
      carry_d[0] = c_q;
      for (int i = 0; i < 4; i++) begin
         carry_d[i+1] = gen_d[i] | (prop_d[i] & carry_d[i]);
      end
      nib_sum_d = a_nib ^ b_nib ^ carry_d[3:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= op_sub ? ~b_in : b_in;
                  c_q     <= op_sub;
                  k_q     <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               for (int n = 0; n < NIBBLES; n++) begin
                  if (k_q == KW'(n)) sum_q[4*n +: 4] <= nib_sum_d;
               end
               c_q <= carry_d[4];
               if (k_q == K_LAST) begin
                  // Overflow is the carry into the sign bit XOR the carry out of it.
                  cout_q  <= carry_d[4];
                  ovf_q   <= carry_d[3] ^ carry_d[4];
                  k_q     <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq (NIBBLES = 4): directed vector table,
// hand-written reset and handshake sequences, then random operations
// compared against a plain-arithmetic reference model.

module tb_serial_add_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          op_sub = 1'b0;
   logic [W-1:0]  a_in = '0;
   logic [W-1:0]  b_in = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   int n_pass = 0;
   int n_total = 0;

   serial_add_seq #(.NIBBLES(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  e_sum;
      logic          e_cout;
      logic          e_ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: whole-word two's-complement arithmetic.
   task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic c, output logic o);
      logic [W:0] full;
      logic       sa, sb_eff;
      if (op) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else    full = {1'b0, a} + {1'b0, b};
      s  = full[W-1:0];
      c  = full[W];
      sa = a[W-1];
      sb_eff = op ? ~b[W-1] : b[W-1];
      o  = (sa == sb_eff) && (s[W-1] != sa);
   endtask

   // Start one op, scramble inputs while running, wait for done (bounded).
   task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic c, output logic o,
                        output int lat, output int busy_cnt);
      @(negedge clk);
      start = 1'b1; op_sub = op; a_in = a; b_in = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         a_in = W'($urandom); b_in = W'($urandom); op_sub = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      s = sum; c = cout; o = ovf;
   endtask

   initial begin
      logic [W-1:0] s, es;
      logic         c, o, ec, eo;
      int           lat, bc;

      vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

      #12;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_sum",  64'(sum),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, s, c, o, lat, bc);
         chk($sformatf("vec%0d_lat", i),  64'(lat), 64'(N + 1));
         chk($sformatf("vec%0d_busy", i), 64'(bc),  64'(N));
         chk($sformatf("vec%0d_sum", i),  64'(s),   64'(vecs[i].e_sum));
         chk($sformatf("vec%0d_cout", i), 64'(c),   64'(vecs[i].e_cout));
         chk($sformatf("vec%0d_ovf", i),  64'(o),   64'(vecs[i].e_ovf));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_done_drop", i), 64'(done), 64'd0);
         chk($sformatf("vec%0d_hold", i), 64'({busy, sum, cout, ovf}),
             64'({1'b0, vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf}));
      end

      // Asynchronous reset in the middle of a run (after E2).
      @(negedge clk);
      start = 1'b1; op_sub = 1'b0; a_in = 16'h1234; b_in = 16'h4321;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrun_partial_sum", 64'(sum), 64'h0055);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_outs", 64'({busy, done, sum, cout, ovf}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b0, 16'h1234, 16'h4321, s, c, o, lat, bc);
      chk("post_rst_lat", 64'(lat), 64'(N + 1));
      chk("post_rst_sum", 64'({s, c, o}), 64'({16'h5555, 1'b0, 1'b0}));

      // Handshake: start pulse at E2 is ignored; start held in DONE re-enters RUN.
      @(negedge clk);
      start = 1'b1; op_sub = 1'b0; a_in = 16'h1234; b_in = 16'h4321;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hs_busy_e0", 64'(busy), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      start = 1'b1; op_sub = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hs_ignored_lat", 64'(lat), 64'(N + 1));
      chk("hs_ignored_sum", 64'({sum, cout, ovf}), 64'({16'h5555, 1'b0, 1'b0}));
      @(negedge clk);
      start = 1'b1; op_sub = 1'b0; a_in = 16'h7FFF; b_in = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_overlap", 64'({done, busy}), 64'({1'b0, 1'b1}));
      chk("b2b_sum_clear", 64'(sum), 64'd0);
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_lat", 64'(lat), 64'(N + 1));
      chk("b2b_result", 64'({sum, cout, ovf}), 64'({16'h8000, 1'b0, 1'b1}));

      // Random operations, sometimes with edge-biased operands.
      for (int t = 0; t < 40; t++) begin
         logic          rop;
         logic [W-1:0]  ra, rb;
         rop = 1'($urandom);
         ra  = W'($urandom);
         rb  = W'($urandom);
         if (t % 5 == 0) ra = {1'b0, {(W-1){1'b1}}};
         if (t % 7 == 0) rb = {1'b1, {(W-1){1'b0}}};
         model(rop, ra, rb, es, ec, eo);
         do_op(rop, ra, rb, s, c, o, lat, bc);
         chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(N + 1));
         chk($sformatf("rnd%0d_res op=%0d a=%0h b=%0h", t, rop, ra, rb),
             64'({s, c, o}), 64'({es, ec, eo}));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
